// File: rtl/bus_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_seq_pkg: shared types and defaults for master_cmd_sequencer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bus_seq_pkg;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_GAP_CYCLES = 40;
  localparam int DEF_RD_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic        mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } seq_cmd_t;

endpackage
`default_nettype wire

// File: rtl/seq_cmd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_cmd_fifo: power-of-two command queue, show-ahead read port   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_cmd_fifo
  import bus_seq_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  seq_cmd_t               push_data,
  input  logic                   pop,
  output seq_cmd_t               pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  seq_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/master_cmd_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | master_cmd_sequencer: queues bus commands and paces master_port  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module master_cmd_sequencer
  import bus_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_mode,
  input  logic [15:0]                 cmd_addr,
  input  logic [7:0]                  cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [7:0]                  rsp_rdata,
  output logic [15:0]                 rsp_addr,
  output logic                        rsp_err,
  output logic                        m_start,
  output logic                        m_mode,
  output logic [15:0]                 m_addr,
  output logic [7:0]                  m_wr_data,
  input  logic [7:0]                  m_rd_data,
  input  logic                        m_wr_en,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_MAX = (GAP_CYCLES > RD_TIMEOUT) ? GAP_CYCLES : RD_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] RD_LAST  = (RD_TIMEOUT > 0) ? CNT_W'(RD_TIMEOUT - 1) : '0;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_mode_q, m_mode_d;
  logic [15:0]      m_addr_q, m_addr_d;
  logic [7:0]       m_wr_data_q, m_wr_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic [15:0]      rsp_addr_q, rsp_addr_d;
  logic             rsp_err_q, rsp_err_d;

  seq_cmd_t fifo_head;
  seq_cmd_t fifo_in;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;

  assign fifo_in = '{mode: cmd_mode, addr: cmd_addr, wdata: cmd_wdata};

  seq_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cmd_valid && cmd_ready),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign m_start   = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign m_mode    = m_mode_q;
  assign m_addr    = m_addr_q;
  assign m_wr_data = m_wr_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_mode_d    = m_mode_q;
    m_addr_d    = m_addr_q;
    m_wr_data_d = m_wr_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // An unconsumed response blocks every launch, not just reads.
        if (!fifo_empty && !rsp_valid_q) begin
          fifo_pop    = 1'b1;
          m_mode_d    = fifo_head.mode;
          m_addr_d    = fifo_head.addr;
          m_wr_data_d = fifo_head.wdata;
          cnt_d       = '0;
          state_d     = fifo_head.mode ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_READ: begin
        if (m_wr_en) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_rd_data;
          rsp_addr_d  = m_addr_q;
          rsp_err_d   = 1'b0;
          cnt_d       = '0;
          state_d     = ST_GAP;
        end else if (cnt_q == RD_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 8'h00;
          rsp_addr_d  = m_addr_q;
          rsp_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      m_mode_q    <= 1'b0;
      m_addr_q    <= '0;
      m_wr_data_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_mode_q    <= m_mode_d;
      m_addr_q    <= m_addr_d;
      m_wr_data_q <= m_wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_master_cmd_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_master_cmd_sequencer: scoreboard bench for the sequencer      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_master_cmd_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 40;
  localparam int RD_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_rdata;
  logic [15:0] rsp_addr;
  logic        rsp_err;
  logic        m_start;
  logic        m_mode;
  logic [15:0] m_addr;
  logic [7:0]  m_wr_data;
  logic [7:0]  m_rd_data = '0;
  logic        m_wr_en = 1'b0;
  logic        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  master_cmd_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_addr   (rsp_addr),
    .rsp_err    (rsp_err),
    .m_start    (m_start),
    .m_mode     (m_mode),
    .m_addr     (m_addr),
    .m_wr_data  (m_wr_data),
    .m_rd_data  (m_rd_data),
    .m_wr_en    (m_wr_en),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          len;
  } exp_cmd_t;

  typedef struct {
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic        err;
  } exp_rsp_t;

  exp_cmd_t cmd_q[$];
  exp_rsp_t rsp_q[$];

  int checks = 0;
  int failures = 0;
  int launches = 0;

  int         rd_delay = 0;
  logic [7:0] rd_value = '0;
  logic       spurious = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic mode, input logic [15:0] addr, input logic [7:0] wdata,
                      input int len, output int stalls);
    stalls    = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (cmd_ready !== 1'b1 && stalls < 500) begin
      tick();
      stalls++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_ready: cmd_ready stayed low for %0d cycles, addr 0x%0h", stalls, addr);
    end else begin
      cmd_q.push_back('{mode: mode, addr: addr, wdata: wdata, len: len});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, 32'(n < bound), 1);
  endtask

  // Master-port model: read data arrives in the rd_delay-th cycle of m_start.
  initial begin
    int rd_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_start === 1'b1 && m_mode === 1'b0) begin
        rd_cyc++;
        m_wr_en = (rd_delay != 0) && (rd_cyc == rd_delay);
      end else begin
        rd_cyc  = 0;
        m_wr_en = spurious;
      end
      m_rd_data = rd_value;
    end
  end

  // Monitor: matches launches and responses against the scoreboard queues.
  initial begin
    exp_cmd_t    cur;
    exp_rsp_t    er;
    int          len = 0;
    logic        active = 1'b0;
    logic        prev_pend = 1'b0;
    logic [24:0] prev_rsp = '0;
    cur = '{mode: 1'b0, addr: '0, wdata: '0, len: -1};
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        active    = 1'b0;
        prev_pend = 1'b0;
      end else begin
        if (m_start === 1'b1) begin
          if (!active) begin
            launches++;
            active = 1'b1;
            len    = 1;
            if (cmd_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL launch_unexpected: m_addr 0x%0h with nothing expected", m_addr);
              cur.len = -1;
            end else begin
              cur = cmd_q.pop_front();
              chk("launch_mode", 32'(m_mode), 32'(cur.mode));
              chk("launch_addr", 32'(m_addr), 32'(cur.addr));
              chk("launch_wdata", 32'(m_wr_data), 32'(cur.wdata));
            end
          end else begin
            len++;
          end
        end else if (active) begin
          active = 1'b0;
          if (cur.len >= 0) chk("m_start_len", len, cur.len);
        end

        if (prev_pend)
          chk("rsp_hold", {rsp_valid, rsp_rdata, rsp_addr, rsp_err}, {1'b1, prev_rsp});

        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
          if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: addr 0x%0h with nothing expected", rsp_addr);
          end else begin
            er = rsp_q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(er.rdata));
            chk("rsp_addr", 32'(rsp_addr), 32'(er.addr));
            chk("rsp_err", 32'(rsp_err), 32'(er.err));
          end
        end
        prev_pend = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
        prev_rsp  = {rsp_rdata, rsp_addr, rsp_err};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int n;
    int l0;

    // Reset values
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_m_start", 32'(m_start), 0);
    chk("rst_m_mode", 32'(m_mode), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_m_wr_data", 32'(m_wr_data), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_addr", 32'(rsp_addr), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    rstn = 1'b1;
    tick();

    // Single write with stray m_wr_en pulses that must be ignored
    spurious = 1'b1;
    send(1'b1, 16'hC123, 8'h5A, 1, st);
    chk("t1_lat_push_no_start", 32'(m_start), 0);
    chk("t1_count_after_push", 32'(fifo_count), 1);
    tick();
    chk("t1_lat_start", 32'(m_start), 1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("t1_busy_cycles", n, 1 + GAP_CYCLES);
    chk("t1_no_rsp", 32'(rsp_valid), 0);
    spurious = 1'b0;

    // Read answered in the 10th cycle
    rd_delay = 10;
    rd_value = 8'h3C;
    rsp_q.push_back('{rdata: 8'h3C, addr: 16'h1ABC, err: 1'b0});
    send(1'b0, 16'h1ABC, 8'h00, 10, st);
    wait_idle("t2", 400);
    chk("t2_rsp_drained", rsp_q.size(), 0);

    // Five commands while the queue cannot drain
    rd_delay = 3;
    rd_value = 8'h96;
    rsp_q.push_back('{rdata: 8'h96, addr: 16'h2003, err: 1'b0});
    send(1'b1, 16'h0100, 8'h11, 1, st);
    send(1'b1, 16'h2001, 8'hA1, 1, st);
    send(1'b1, 16'h2002, 8'hA2, 1, st);
    send(1'b0, 16'h2003, 8'hA3, 3, st);
    send(1'b1, 16'h2004, 8'hA4, 1, st);
    chk("t3_full_ready", 32'(cmd_ready), 0);
    chk("t3_full_count", 32'(fifo_count), 4);
    send(1'b1, 16'h2005, 8'hA5, 1, st);
    chk("t3_fifth_stalled", 32'(st > 0), 1);
    chk("t3_count_after_fifth", 32'(fifo_count), 4);
    chk("t3_head_addr", 32'(m_addr), 32'h2001);
    wait_idle("t3", 1000);

    // Read timeout
    rd_delay = 0;
    rd_value = 8'hEE;
    rsp_q.push_back('{rdata: 8'h00, addr: 16'h0F0F, err: 1'b1});
    send(1'b0, 16'h0F0F, 8'h3C, RD_TIMEOUT, st);
    wait_idle("t4", 600);

    // Pending response stalls the following write
    rsp_ready = 1'b0;
    rd_delay  = 5;
    rd_value  = 8'hC7;
    rsp_q.push_back('{rdata: 8'hC7, addr: 16'h3456, err: 1'b0});
    l0 = launches;
    send(1'b0, 16'h3456, 8'h00, 5, st);
    send(1'b1, 16'h789A, 8'h42, 1, st);
    repeat (100) tick();
    chk("t5_one_launch", launches, l0 + 1);
    chk("t5_rsp_pending", 32'(rsp_valid), 1);
    chk("t5_write_queued", 32'(fifo_count), 1);
    chk("t5_no_start", 32'(m_start), 0);
    rsp_ready = 1'b1;
    tick();
    chk("t5_rsp_cleared", 32'(rsp_valid), 0);
    chk("t5_no_start_at_accept", 32'(m_start), 0);
    tick();
    chk("t5_write_start", 32'(m_start), 1);
    chk("t5_write_addr", 32'(m_addr), 32'h789A);
    wait_idle("t5", 200);

    // Reset during a read with two commands queued
    rd_delay = 0;
    send(1'b0, 16'h5555, 8'h00, RD_TIMEOUT, st);
    send(1'b1, 16'h6666, 8'h01, 1, st);
    send(1'b1, 16'h7777, 8'h02, 1, st);
    repeat (3) tick();
    chk("t6_pre_count", 32'(fifo_count), 2);
    chk("t6_pre_start", 32'(m_start), 1);
    rstn = 1'b0;
    tick();
    chk("t6_m_start", 32'(m_start), 0);
    chk("t6_fifo_count", 32'(fifo_count), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    rstn = 1'b1;
    cmd_q.delete();
    tick();
    send(1'b1, 16'hBEEF, 8'h99, 1, st);
    wait_idle("t6", 200);

    chk("end_cmd_q_empty", cmd_q.size(), 0);
    chk("end_rsp_q_empty", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
